// File: rtl/pattern_sel.sv
// Test-pattern selector: turns debounced button press counters into the active pattern id.
// Requests are latched per frame and applied only on the vsync rising edge; a command press toggles auto-cycle.
module pattern_sel #(
    parameter int unsigned NUM_PAT     = 16,
    parameter int unsigned PAT_W       = 4,
    parameter int unsigned AUTO_FRAMES = 120,
    parameter int unsigned FCNT_W      = 8
) (
    input  logic             iclk,
    input  logic             irst,
    input  logic             ivsync,
    input  logic [7:0]       ibtn0_index,
    input  logic [7:0]       ibtn1_index,
    input  logic [7:0]       ibtn2_index,
    output logic [PAT_W-1:0] opattern_id,
    output logic             oauto_mode,
    output logic             opat_update
);
    typedef enum logic {
        MANUAL = 1'b0,
        AUTO   = 1'b1
    } mode_t;

    localparam logic [PAT_W-1:0]  LAST_PAT = PAT_W'(NUM_PAT - 1);
    localparam logic [FCNT_W-1:0] LAST_FRM = FCNT_W'(AUTO_FRAMES - 1);

    mode_t             r_mode, w_mode_nxt;
    logic [1:0]        r_vs_sr;
    logic [7:0]        r_prev0, r_prev1, r_prev2;
    logic              r_init;
    logic              r_fwd_p, r_bwd_p, r_cmd_p;
    logic [FCNT_W-1:0] r_fcnt, w_fcnt_nxt;
    logic [PAT_W-1:0]  w_id_nxt, w_id_inc, w_id_dec;
    logic              w_vs_rise, w_ev0, w_ev1, w_ev2, w_fwd, w_bwd;

    assign w_vs_rise = (r_vs_sr == 2'b01);
    assign w_ev0     = r_init && (ibtn0_index != r_prev0);
    assign w_ev1     = r_init && (ibtn1_index != r_prev1);
    assign w_ev2     = r_init && (ibtn2_index != r_prev2);
    // Simultaneous forward and backward requests cancel each other.
    assign w_fwd     = r_fwd_p && !r_bwd_p;
    assign w_bwd     = r_bwd_p && !r_fwd_p;
    assign w_id_inc  = (opattern_id == LAST_PAT) ? '0 : opattern_id + 1'b1;
    assign w_id_dec  = (opattern_id == '0) ? LAST_PAT : opattern_id - 1'b1;
    assign oauto_mode = (r_mode == AUTO);

    always_ff @(posedge iclk or negedge irst) begin
        if (!irst) begin
            r_mode <= MANUAL;
        end else begin
            r_mode <= w_mode_nxt;
        end
    end

    always_comb begin
        w_mode_nxt = r_mode;
        w_fcnt_nxt = r_fcnt;
        w_id_nxt   = opattern_id;
        if (w_vs_rise) begin
            if (r_cmd_p) begin
                w_mode_nxt = (r_mode == MANUAL) ? AUTO : MANUAL;
                w_fcnt_nxt = '0;
            end
            if (w_fwd) begin
                w_id_nxt   = w_id_inc;
                w_fcnt_nxt = '0;
            end else if (w_bwd) begin
                w_id_nxt   = w_id_dec;
                w_fcnt_nxt = '0;
            end else if (!r_cmd_p && r_mode == AUTO) begin
                if (r_fcnt == LAST_FRM) begin
                    w_fcnt_nxt = '0;
                    w_id_nxt   = w_id_inc;
                end else begin
                    w_fcnt_nxt = r_fcnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge iclk or negedge irst) begin
        if (!irst) begin
            r_vs_sr     <= '0;
            r_prev0     <= '0;
            r_prev1     <= '0;
            r_prev2     <= '0;
            r_init      <= 1'b0;
            r_fwd_p     <= 1'b0;
            r_bwd_p     <= 1'b0;
            r_cmd_p     <= 1'b0;
            r_fcnt      <= '0;
            opattern_id <= '0;
            opat_update <= 1'b0;
        end else begin
            r_vs_sr     <= {r_vs_sr[0], ivsync};
            r_prev0     <= ibtn0_index;
            r_prev1     <= ibtn1_index;
            r_prev2     <= ibtn2_index;
            r_init      <= 1'b1;
            // A press seen on the boundary cycle survives the clear and waits for the next frame.
            r_fwd_p     <= w_ev0 || (r_fwd_p && !w_vs_rise);
            r_bwd_p     <= w_ev1 || (r_bwd_p && !w_vs_rise);
            r_cmd_p     <= w_ev2 || (r_cmd_p && !w_vs_rise);
            r_fcnt      <= w_fcnt_nxt;
            opattern_id <= w_id_nxt;
            opat_update <= (w_id_nxt != opattern_id);
        end
    end
endmodule

// File: tb/tb_pattern_sel.sv
// Self-checking bench for pattern_sel (NUM_PAT=4, AUTO_FRAMES=3): directed steps then random frames,
// compared against a frame-level reference model of pending requests, mode and frame count.
module tb_pattern_sel;
    localparam int NP = 4;
    localparam int AF = 3;

    logic       iclk = 1'b0;
    logic       irst = 1'b0;
    logic       ivsync = 1'b0;
    logic [7:0] b0 = '0, b1 = '0, b2 = '0;
    logic [1:0] id;
    logic       am, upd;

    int total = 0;
    int bad   = 0;

    // reference model: requests seen this frame, active id, mode, frames spent in auto since last step
    int m_id   = 0;
    bit m_auto = 0;
    int m_cnt  = 0;
    bit p_f = 0, p_b = 0, p_c = 0;

    pattern_sel #(
        .NUM_PAT(4),
        .PAT_W(2),
        .AUTO_FRAMES(3),
        .FCNT_W(2)
    ) dut (
        .iclk(iclk),
        .irst(irst),
        .ivsync(ivsync),
        .ibtn0_index(b0),
        .ibtn1_index(b1),
        .ibtn2_index(b2),
        .opattern_id(id),
        .oauto_mode(am),
        .opat_update(upd)
    );

    always #5 iclk = ~iclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge iclk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            chk("no_pulse", 32'(upd), 32'd0);
        end
    endtask

    task automatic press_now(input int btn);
        logic [7:0] d;
        d = 8'($urandom_range(1, 255));
        case (btn)
            0: begin b0 = b0 + d; p_f = 1; end
            1: begin b1 = b1 + d; p_b = 1; end
            default: begin b2 = b2 + d; p_c = 1; end
        endcase
    endtask

    task automatic press(input int btn);
        press_now(btn);
        tick();
    endtask

    task automatic model_frame();
        bit step;
        step = p_f ^ p_b;
        if (step) begin
            m_id  = p_f ? (m_id + 1) % NP : (m_id + NP - 1) % NP;
            m_cnt = 0;
        end
        if (p_c) begin
            m_auto = !m_auto;
            m_cnt  = 0;
        end else if (!step && m_auto) begin
            m_cnt++;
            if (m_cnt == AF) begin
                m_cnt = 0;
                m_id  = (m_id + 1) % NP;
            end
        end
        p_f = 0;
        p_b = 0;
        p_c = 0;
    endtask

    // late_btn >= 0 presses that button in the very cycle the boundary is detected
    task automatic frame(input int late_btn);
        int old;
        ivsync = 1'b1;
        tick();
        old = m_id;
        model_frame();
        if (late_btn >= 0) press_now(late_btn);
        tick();
        ivsync = 1'b0;
        chk("id", 32'(id), 32'(m_id));
        chk("auto", 32'(am), 32'(m_auto));
        chk("pulse", 32'(upd), 32'(m_id != old));
        tick();
        chk("pulse_end", 32'(upd), 32'd0);
        idle(2);
    endtask

    task automatic do_reset(input logic [7:0] v0);
        ivsync = 1'b0;
        irst   = 1'b0;
        #1;
        chk("rst_id", 32'(id), 32'd0);
        chk("rst_auto", 32'(am), 32'd0);
        chk("rst_pulse", 32'(upd), 32'd0);
        b0 = v0;
        tick();
        tick();
        irst   = 1'b1;
        m_id   = 0;
        m_auto = 0;
        m_cnt  = 0;
        p_f = 0;
        p_b = 0;
        p_c = 0;
        idle(2);
    endtask

    initial begin
        int late;
        tick();
        // 1: idle frames, then release with a nonzero index
        do_reset(8'd0);
        for (int i = 0; i < 3; i++) frame(-1);
        do_reset(8'd5);
        for (int i = 0; i < 2; i++) frame(-1);

        // 2: single forward presses, one per frame, plus the 254->0 counter wrap
        for (int i = 0; i < 4; i++) begin
            press(0);
            idle(1);
            frame(-1);
        end
        b0 = 8'd254; p_f = 1; tick();
        frame(-1);
        b0 = 8'd0; p_f = 1; tick();
        frame(-1);

        // 3: backward steps, two presses in one frame collapse
        press(1);
        frame(-1);
        press(1);
        idle(1);
        press(1);
        frame(-1);

        // 4: forward and backward in one frame cancel; nothing left pending afterwards
        press(0);
        press(1);
        frame(-1);
        frame(-1);

        // 5: auto mode, manual step inside auto, leave auto
        press(2);
        frame(-1);
        for (int i = 0; i < 4; i++) frame(-1);
        press(0);
        frame(-1);
        for (int i = 0; i < 4; i++) frame(-1);
        press(2);
        frame(-1);
        for (int i = 0; i < 4; i++) frame(-1);

        // 6: press on the boundary cycle is deferred; reset discards a pending request
        frame(0);
        frame(-1);
        press(0);
        do_reset(b0);
        for (int i = 0; i < 2; i++) frame(-1);

        // random frames
        for (int f = 0; f < 40; f++) begin
            for (int n = $urandom_range(0, 2); n > 0; n--) press(0);
            for (int n = $urandom_range(0, 2); n > 0; n--) press(1);
            if ($urandom_range(0, 5) == 0) press(2);
            idle(1);
            late = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 2)) : -1;
            frame(late);
        end
        frame(-1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
